control_estacionamiento: RTL

//  Single-lane gate controller for the parking lot. Arbitrates entry and exit requests onto one

---
 rtl/control_estacionamiento_if.sv | 26 ++
 rtl/control_estacionamiento.sv | 122 ++++++++++++
 2 files changed

// File: rtl/control_estacionamiento_if.sv
// rtl/control_estacionamiento_if.sv - gate lane signal bundle between sensors/counter and the gate controller
interface control_estacionamiento_if #(
  parameter int ANCHO = 3
);
  logic             sensor_entrada;
  logic             sensor_salida;
  logic             paso_entrada;
  logic             paso_salida;
  logic [ANCHO-1:0] autos;
  logic             barrera_entrada;
  logic             barrera_salida;
  logic             entrada;
  logic             salida;
  logic             lleno;
  logic             denegado;

  modport master (
    output sensor_entrada, sensor_salida, paso_entrada, paso_salida, autos,
    input  barrera_entrada, barrera_salida, entrada, salida, lleno, denegado
  );

  modport slave (
    input  sensor_entrada, sensor_salida, paso_entrada, paso_salida, autos,
    output barrera_entrada, barrera_salida, entrada, salida, lleno, denegado
  );
endinterface

// File: rtl/control_estacionamiento.sv
// rtl/control_estacionamiento.sv - single-lane parking gate controller with round-robin entry/exit arbitration
module control_estacionamiento #(
  parameter int ANCHO     = 3,
  parameter int CAPACIDAD = 7,
  parameter int T_ABIERTA = 100,
  parameter int T_GUARDA  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  control_estacionamiento_if.slave bus
);
  typedef enum logic [1:0] {LIBRE, ABRE_ENT, ABRE_SAL, GUARDA} estado_t;

  localparam int TMAX = (T_ABIERTA > T_GUARDA) ? T_ABIERTA : T_GUARDA;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [ANCHO:0]  CAP       = (ANCHO + 1)'(CAPACIDAD);
  localparam logic [TW-1:0]   FIN_ABRE  = TW'(T_ABIERTA - 1);
  localparam logic [TW-1:0]   FIN_GUARD = TW'(T_GUARDA - 1);

  estado_t       estado, estado_n;
  logic [TW-1:0] timer, timer_n;
  logic          ultimo_ent, ultimo_ent_n;
  logic          be, be_n, bs, bs_n;
  logic          ent, ent_n, sal, sal_n;
  logic          den, den_n;
  logic          lleno_c, ent_ok, sal_ok;

  assign lleno_c = {1'b0, bus.autos} >= CAP;
  assign ent_ok  = bus.sensor_entrada & ~lleno_c;
  assign sal_ok  = bus.sensor_salida & (bus.autos != '0);

  assign bus.lleno           = lleno_c;
  assign bus.barrera_entrada = be;
  assign bus.barrera_salida  = bs;
  assign bus.entrada         = ent;
  assign bus.salida          = sal;
  assign bus.denegado        = den;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= LIBRE;
      timer      <= '0;
      ultimo_ent <= 1'b0;
      be         <= 1'b0;
      bs         <= 1'b0;
      ent        <= 1'b0;
      sal        <= 1'b0;
      den        <= 1'b0;
    end else begin
      estado     <= estado_n;
      timer      <= timer_n;
      ultimo_ent <= ultimo_ent_n;
      be         <= be_n;
      bs         <= bs_n;
      ent        <= ent_n;
      sal        <= sal_n;
      den        <= den_n;
    end
  end

  // Barriers and pulses are recomputed every cycle, so any exit from ABRE_x drops the barrier.
  always_comb begin
    estado_n     = estado;
    timer_n      = timer;
    ultimo_ent_n = ultimo_ent;
    be_n         = 1'b0;
    bs_n         = 1'b0;
    ent_n        = 1'b0;
    sal_n        = 1'b0;
    den_n        = 1'b0;
    case (estado)
      LIBRE: begin
        den_n   = bus.sensor_entrada & lleno_c;
        timer_n = '0;
        if (ent_ok && (!sal_ok || !ultimo_ent)) begin
          estado_n     = ABRE_ENT;
          be_n         = 1'b1;
          ultimo_ent_n = 1'b1;
        end else if (sal_ok) begin
          estado_n     = ABRE_SAL;
          bs_n         = 1'b1;
          ultimo_ent_n = 1'b0;
        end
      end
      ABRE_ENT: begin
        if (bus.paso_entrada) begin
          ent_n    = 1'b1;
          estado_n = GUARDA;
          timer_n  = '0;
        end else if (timer == FIN_ABRE) begin
          estado_n = GUARDA;
          timer_n  = '0;
        end else begin
          be_n    = 1'b1;
          timer_n = timer + 1'b1;
        end
      end
      ABRE_SAL: begin
        if (bus.paso_salida) begin
          sal_n    = 1'b1;
          estado_n = GUARDA;
          timer_n  = '0;
        end else if (timer == FIN_ABRE) begin
          estado_n = GUARDA;
          timer_n  = '0;
        end else begin
          bs_n    = 1'b1;
          timer_n = timer + 1'b1;
        end
      end
      GUARDA: begin
        if (timer == FIN_GUARD) begin
          estado_n = LIBRE;
          timer_n  = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: estado_n = LIBRE;
    endcase
  end
endmodule
